// File: rtl/cvxif_copro_responder_if.sv
// CV-X-IF issue/commit/result bundle between core and coprocessor.
// master = core side, slave = coprocessor side.
interface cvxif_copro_responder_if #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned IdWidth = 3
);
   logic               issue_valid_i;
   logic               issue_ready_o;
   logic [31:0]        issue_instr_i;
   logic [IdWidth-1:0] issue_id_i;
   logic [XLEN-1:0]    issue_rs1_i;
   logic [XLEN-1:0]    issue_rs2_i;
   logic               issue_accept_o;
   logic               issue_writeback_o;
   logic               commit_valid_i;
   logic [IdWidth-1:0] commit_id_i;
   logic               commit_kill_i;
   logic               result_valid_o;
   logic               result_ready_i;
   logic [IdWidth-1:0] result_id_o;
   logic [4:0]         result_rd_o;
   logic               result_we_o;
   logic [XLEN-1:0]    result_data_o;

   modport master (
      output issue_valid_i, issue_instr_i, issue_id_i,
      output issue_rs1_i, issue_rs2_i,
      output commit_valid_i, commit_id_i, commit_kill_i,
      output result_ready_i,
      input  issue_ready_o, issue_accept_o, issue_writeback_o,
      input  result_valid_o, result_id_o, result_rd_o,
      input  result_we_o, result_data_o
   );

   modport slave (
      input  issue_valid_i, issue_instr_i, issue_id_i,
      input  issue_rs1_i, issue_rs2_i,
      input  commit_valid_i, commit_id_i, commit_kill_i,
      input  result_ready_i,
      output issue_ready_o, issue_accept_o, issue_writeback_o,
      output result_valid_o, result_id_o, result_rd_o,
      output result_we_o, result_data_o
   );
endinterface

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: custom-0 ALU ops, results held
// in an in-order buffer until commit/kill, then returned in issue order.
module cvxif_copro_responder #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned IdWidth   = 3,
   parameter int unsigned NrEntries = 4
) (
   input logic                     clk_i,
   input logic                     rst_ni,
   cvxif_copro_responder_if.slave  bus
);
   localparam int unsigned PtrW = $clog2(NrEntries);
   localparam logic [PtrW:0] Depth = (PtrW+1)'(NrEntries);

   typedef enum logic [1:0] {
      FREE, ISSUED, COMMITTED, KILLED
   } ent_state_e;

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic [4:0]         rd;
      logic               we;
      logic [XLEN-1:0]    data;
   } ent_t;

   ent_state_e      st_q   [NrEntries];
   ent_state_e      st_d   [NrEntries];
   ent_t            ent_q  [NrEntries];
   ent_t            ent_d  [NrEntries];
   logic [PtrW-1:0] head_q, head_d;
   logic [PtrW-1:0] tail_q, tail_d;
   logic [PtrW:0]   count_q, count_d;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      rd;
   logic            accept;
   logic [XLEN-1:0] alu;
   logic            ready;
   logic            push;
   logic            pop;
   ent_state_e      head_st;
   logic            unused_rs;

   assign opcode    = bus.issue_instr_i[6:0];
   assign rd        = bus.issue_instr_i[11:7];
   assign funct3    = bus.issue_instr_i[14:12];
   assign funct7    = bus.issue_instr_i[31:25];
   assign unused_rs = ^bus.issue_instr_i[24:15];

   always_comb begin
      accept = 1'b0;
      alu    = '0;
      if (opcode == 7'b0001011 && funct7 == 7'd0) begin
         unique case (funct3)
            3'b000: begin
               accept = 1'b1;
               alu    = bus.issue_rs1_i + bus.issue_rs2_i;
            end
            3'b001: begin
               accept = 1'b1;
               alu    = bus.issue_rs1_i - bus.issue_rs2_i;
            end
            3'b010: begin
               accept = 1'b1;
               alu    = bus.issue_rs1_i & ~bus.issue_rs2_i;
            end
            3'b011: begin
               accept = 1'b1;
               alu    = (bus.issue_rs1_i < bus.issue_rs2_i)
                        ? bus.issue_rs1_i : bus.issue_rs2_i;
            end
            default: ;
         endcase
      end
   end

   // Ready depends only on registered occupancy; a pop frees space next cycle.
   assign ready   = (count_q < Depth);
   assign push    = bus.issue_valid_i & ready & accept;
   assign head_st = st_q[head_q];
   assign pop     = (head_st == COMMITTED && bus.result_ready_i)
                  || (head_st == KILLED);

   assign bus.issue_ready_o     = ready;
   assign bus.issue_accept_o    = accept;
   assign bus.issue_writeback_o = accept & (rd != 5'd0);

   assign bus.result_valid_o = (head_st == COMMITTED);
   assign bus.result_id_o    = bus.result_valid_o ? ent_q[head_q].id   : '0;
   assign bus.result_rd_o    = bus.result_valid_o ? ent_q[head_q].rd   : '0;
   assign bus.result_we_o    = bus.result_valid_o & ent_q[head_q].we;
   assign bus.result_data_o  = bus.result_valid_o ? ent_q[head_q].data : '0;

   always_comb begin
      st_d    = st_q;
      ent_d   = ent_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      // Only entries already ISSUED can match, so a same-cycle alloc is skipped.
      for (int i = 0; i < NrEntries; i++) begin
         if (bus.commit_valid_i && st_q[i] == ISSUED
             && ent_q[i].id == bus.commit_id_i) begin
            st_d[i] = bus.commit_kill_i ? KILLED : COMMITTED;
         end
      end
      if (push) begin
         st_d[tail_q]  = ISSUED;
         ent_d[tail_q] = '{id:   bus.issue_id_i,
                           rd:   rd,
                           we:   (rd != 5'd0),
                           data: alu};
         tail_d        = tail_q + 1'b1;
      end
      if (pop) begin
         st_d[head_q] = FREE;
         head_d       = head_q + 1'b1;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < NrEntries; i++) begin
            st_q[i]  <= FREE;
            ent_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < NrEntries; i++) begin
            st_q[i]  <= st_d[i];
            ent_q[i] <= ent_d[i];
         end
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Directed bench for cvxif_copro_responder with an issue-order
// scoreboard checked by a result monitor.
module tb_cvxif_copro_responder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cvxif_copro_responder_if #(.XLEN(32), .IdWidth(3)) bus ();

   cvxif_copro_responder #(
      .XLEN(32), .IdWidth(3), .NrEntries(4)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [2:0]  id;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] data;
      bit          killed;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int passes = 0;
   int rx = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] mk(input logic [2:0] f3,
                                      input logic [4:0] rd);
      mk = {7'd0, 5'd12, 5'd11, f3, rd, 7'b0001011};
   endfunction

   function automatic void model(input logic [31:0] ins,
                                 input logic [31:0] a, b,
                                 output logic acc, wb,
                                 output logic [31:0] d);
      acc = 1'b0;
      d   = 32'd0;
      if (ins[6:0] == 7'h0B && ins[31:25] == 7'd0) begin
         case (ins[14:12])
            3'd0: begin acc = 1'b1; d = a + b; end
            3'd1: begin acc = 1'b1; d = a - b; end
            3'd2: begin acc = 1'b1; d = a & ~b; end
            3'd3: begin acc = 1'b1; d = (a < b) ? a : b; end
            default: ;
         endcase
      end
      wb = acc && (ins[11:7] != 5'd0);
   endfunction

   // Starts and ends at posedge+1.
   task automatic issue(input logic [31:0] ins, input logic [2:0] id,
                        input logic [31:0] a, b, input bit killed,
                        output int waited);
      logic acc, wb;
      logic [31:0] d;
      exp_t e;
      model(ins, a, b, acc, wb, d);
      bus.issue_valid_i = 1'b1;
      bus.issue_instr_i = ins;
      bus.issue_id_i    = id;
      bus.issue_rs1_i   = a;
      bus.issue_rs2_i   = b;
      #1;
      chk("issue_accept", bus.issue_accept_o, acc);
      chk("issue_writeback", bus.issue_writeback_o, wb);
      waited = 0;
      while (!bus.issue_ready_o && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      if (waited >= 20) chk("issue_timeout", bus.issue_ready_o, 1);
      @(posedge clk); #1;
      bus.issue_valid_i = 1'b0;
      if (acc) begin
         e.id = id; e.rd = ins[11:7]; e.we = wb;
         e.data = d; e.killed = killed;
         q.push_back(e);
      end
   endtask

   task automatic commit(input logic [2:0] id, input logic kill);
      bus.commit_valid_i = 1'b1;
      bus.commit_id_i    = id;
      bus.commit_kill_i  = kill;
      @(posedge clk); #1;
      bus.commit_valid_i = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_rx(input int n);
      int c = 0;
      while (rx < n && c < 50) begin @(posedge clk); #1; c++; end
      chk("rx_count", rx, n);
   endtask

   // Result monitor: pops scoreboard and checks stall stability.
   bit          hold_v = 0;
   logic [2:0]  hold_id;
   logic [4:0]  hold_rd;
   logic        hold_we;
   logic [31:0] hold_data;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         hold_v = 0;
      end else begin
         if (hold_v) begin
            chk("stable_valid", bus.result_valid_o, 1);
            chk("stable_id", bus.result_id_o, hold_id);
            chk("stable_rd", bus.result_rd_o, hold_rd);
            chk("stable_we", bus.result_we_o, hold_we);
            chk("stable_data", bus.result_data_o, hold_data);
         end
         if (bus.result_valid_o && bus.result_ready_i) begin
            while (q.size() > 0 && q[0].killed) void'(q.pop_front());
            chk("result_expected", 64'(q.size() != 0), 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("result_id", bus.result_id_o, e.id);
               chk("result_rd", bus.result_rd_o, e.rd);
               chk("result_we", bus.result_we_o, e.we);
               chk("result_data", bus.result_data_o, e.data);
            end
            rx++;
         end
         hold_v    = bus.result_valid_o && !bus.result_ready_i;
         hold_id   = bus.result_id_o;
         hold_rd   = bus.result_rd_o;
         hold_we   = bus.result_we_o;
         hold_data = bus.result_data_o;
      end
   end

   initial begin
      int w;
      bus.issue_valid_i  = 1'b0;
      bus.issue_instr_i  = '0;
      bus.issue_id_i     = '0;
      bus.issue_rs1_i    = '0;
      bus.issue_rs2_i    = '0;
      bus.commit_valid_i = 1'b0;
      bus.commit_id_i    = '0;
      bus.commit_kill_i  = 1'b0;
      bus.result_ready_i = 1'b1;
      tick(2);
      rst_n = 1'b1;
      chk("rst_valid", bus.result_valid_o, 0);
      chk("rst_ready", bus.issue_ready_o, 1);
      chk("rst_id", bus.result_id_o, 0);
      chk("rst_data", bus.result_data_o, 0);

      // ADD, commit, one-cycle latency
      issue(32'h00C5850B, 3'd1, 32'd5, 32'd7, 0, w);
      commit(3'd1, 1'b0);
      chk("add_latency", bus.result_valid_o, 1);
      wait_rx(1);

      // SUB wrap, rd=0 ADD, MINU, ANDN, non-custom opcode
      issue(mk(3'd1, 5'd5), 3'd2, 32'd0, 32'd1, 0, w);
      commit(3'd2, 1'b0);
      issue(mk(3'd0, 5'd0), 3'd3, 32'd1, 32'd2, 0, w);
      commit(3'd3, 1'b0);
      issue(32'h00C58533, 3'd4, 32'd1, 32'd2, 0, w);
      issue(mk(3'd3, 5'd6), 3'd5, 32'd9, 32'd3, 0, w);
      commit(3'd5, 1'b0);
      issue(mk(3'd2, 5'd7), 3'd6, 32'hF0F0, 32'hFF00, 0, w);
      commit(3'd6, 1'b0);
      wait_rx(5);

      // Fill, out-of-order commits, in-order results
      for (int i = 0; i < 4; i++)
         issue(mk(3'd0, 5'(i + 1)), 3'(i), 32'(i * 100), 32'd3, 0, w);
      chk("full_ready", bus.issue_ready_o, 0);
      commit(3'd2, 1'b0);
      chk("ooo_hold", bus.result_valid_o, 0);
      commit(3'd0, 1'b0);
      chk("head_id0", bus.result_id_o, 0);
      tick(2);
      chk("stall_id1", bus.result_valid_o, 0);
      commit(3'd1, 1'b0);
      commit(3'd3, 1'b0);
      wait_rx(9);

      // Kill drops silently
      issue(mk(3'd1, 5'd8), 3'd4, 32'd50, 32'd8, 1, w);
      issue(mk(3'd0, 5'd9), 3'd5, 32'd40, 32'd2, 0, w);
      commit(3'd4, 1'b1);
      chk("kill_no_valid", bus.result_valid_o, 0);
      commit(3'd5, 1'b0);
      chk("after_kill_valid", bus.result_valid_o, 1);
      chk("after_kill_id", bus.result_id_o, 5);
      wait_rx(10);

      // Full buffer, stalled result, ready with same-cycle issue
      bus.result_ready_i = 1'b0;
      for (int i = 0; i < 4; i++)
         issue(mk(3'd2, 5'(i + 10)), 3'(i), 32'hFFFF_0000 + i, 32'h0F, 0, w);
      for (int i = 0; i < 4; i++) commit(3'(i), 1'b0);
      chk("stall_full", bus.issue_ready_o, 0);
      tick(5);
      bus.result_ready_i = 1'b1;
      chk("no_bypass", bus.issue_ready_o, 0);
      issue(mk(3'd3, 5'd20), 3'd4, 32'd7, 32'd70, 0, w);
      chk("issue_wait", w, 1);
      commit(3'd4, 1'b0);
      wait_rx(15);

      // Reset with pending entries
      bus.result_ready_i = 1'b0;
      issue(mk(3'd0, 5'd1), 3'd1, 32'd1, 32'd1, 0, w);
      issue(mk(3'd0, 5'd2), 3'd2, 32'd2, 32'd2, 0, w);
      issue(mk(3'd0, 5'd3), 3'd3, 32'd3, 32'd3, 0, w);
      commit(3'd1, 1'b0);
      commit(3'd2, 1'b0);
      chk("pre_rst_valid", bus.result_valid_o, 1);
      rst_n = 1'b0;
      tick(1);
      chk("mid_rst_valid", bus.result_valid_o, 0);
      chk("mid_rst_ready", bus.issue_ready_o, 1);
      chk("mid_rst_data", bus.result_data_o, 0);
      q.delete();
      rst_n = 1'b1;
      bus.result_ready_i = 1'b1;
      tick(10);
      chk("no_stale", rx, 15);

      // Operation after reset
      issue(mk(3'd0, 5'd4), 3'd6, 32'hFFFF_FFFF, 32'd2, 0, w);
      commit(3'd6, 1'b0);
      wait_rx(16);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
